acc_mem_arbiter: RTL and testbench

ACC_MEM_ARBITER -- requirements
Module: acc_mem_arbiter

---
 rtl/acc_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_acc_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_mem_arbiter.sv
// Single-port memory arbiter for an accumulator CPU: fetch, operand (direct/indirect)
// and store requesters share one 1024x16 synchronous-read memory.
module acc_mem_arbiter #(
    parameter int INS_WORDS = 401,
    parameter int STARVE    = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        if_req,
    input  logic [9:0]  if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        op_req,
    input  logic [9:0]  op_addr,
    input  logic        op_ind,
    output logic        op_gnt,
    output logic        op_valid,
    output logic        op_err,
    output logic [15:0] op_rdata,
    input  logic        st_req,
    input  logic [9:0]  st_addr,
    input  logic [15:0] st_wdata,
    output logic        st_gnt,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [9:0] BASE    = 10'(INS_WORDS);
    localparam logic [9:0] D_LIMIT = 10'(1024 - INS_WORDS);
    localparam int         CW      = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

    typedef enum logic [1:0] {IDLE, PTR, RD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          rd_fetch, rd_fetch_nxt;
    logic          rd_err, rd_err_nxt;
    logic          if_ok, op_ok, st_ok, ptr_ok;

    assign if_ok  = if_addr < BASE;
    assign op_ok  = op_addr < D_LIMIT;
    assign st_ok  = st_addr < D_LIMIT;
    assign ptr_ok = mem_rdata[9:0] < D_LIMIT;

    // Grants and memory strobes are gated by rst so reset silences them immediately.
    always_comb begin
        if_gnt       = 1'b0;
        op_gnt       = 1'b0;
        st_gnt       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        state_nxt    = state;
        rd_fetch_nxt = rd_fetch;
        rd_err_nxt   = rd_err;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (if_req && starve_cnt == CNT_MAX) if_gnt = 1'b1;
                    else if (st_req)                     st_gnt = 1'b1;
                    else if (op_req)                     op_gnt = 1'b1;
                    else if (if_req)                     if_gnt = 1'b1;

                    if (if_gnt) begin
                        mem_en       = if_ok;
                        mem_addr     = if_addr;
                        rd_fetch_nxt = 1'b1;
                        rd_err_nxt   = !if_ok;
                        state_nxt    = RD;
                    end else if (st_gnt) begin
                        mem_en    = st_ok;
                        mem_we    = st_ok;
                        mem_addr  = BASE + st_addr;
                        mem_wdata = st_wdata;
                    end else if (op_gnt) begin
                        mem_en       = op_ok;
                        mem_addr     = BASE + op_addr;
                        rd_fetch_nxt = 1'b0;
                        rd_err_nxt   = !op_ok;
                        state_nxt    = op_ind ? PTR : RD;
                    end
                end
                PTR: begin
                    // A bad operand address leaves mem_rdata meaningless, so rd_err also gates here.
                    mem_en     = !rd_err && ptr_ok;
                    mem_addr   = BASE + mem_rdata[9:0];
                    rd_err_nxt = rd_err || !ptr_ok;
                    state_nxt  = RD;
                end
                RD:      state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_fetch   <= 1'b0;
            rd_err     <= 1'b0;
            if_valid   <= 1'b0;
            op_valid   <= 1'b0;
            op_err     <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            if_rdata   <= '0;
            op_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            rd_fetch <= rd_fetch_nxt;
            rd_err   <= rd_err_nxt;
            if_valid <= (state == RD) && rd_fetch;
            op_valid <= (state == RD) && !rd_fetch;
            op_err   <= (state == RD) && !rd_fetch && rd_err;
            st_done  <= st_gnt;
            st_err   <= st_gnt && !st_ok;
            if (state == RD && rd_fetch)
                if_rdata <= rd_err ? 16'h0000 : mem_rdata;
            if (state == RD && !rd_fetch)
                op_rdata <= rd_err ? 16'h0000 : mem_rdata;
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (state == IDLE && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Bench for acc_mem_arbiter: memory model, transaction-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_acc_mem_arbiter;

    localparam int INS = 401;
    localparam int STV = 3;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        if_req, op_req, op_ind, st_req;
    logic [9:0]  if_addr, op_addr, st_addr;
    logic [15:0] st_wdata;
    logic        if_gnt, if_valid, op_gnt, op_valid, op_err, st_gnt, st_done, st_err;
    logic [15:0] if_rdata, op_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    int checks = 0;
    int failures = 0;
    int pcyc = 0;

    acc_mem_arbiter #(.INS_WORDS(INS), .STARVE(STV)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .op_req(op_req), .op_addr(op_addr), .op_ind(op_ind), .op_gnt(op_gnt), .op_valid(op_valid),
        .op_err(op_err), .op_rdata(op_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_gnt(st_gnt), .st_done(st_done),
        .st_err(st_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) pcyc <= pcyc + 1;

    function automatic logic [15:0] init_word(input int i);
        case (i)
            0:       return 16'hA5A5;
            3:       return 16'h0F0F;
            403:     return 16'h0007;
            405:     return 16'h0009;
            408:     return 16'h1234;
            421:     return 16'h03FF;
            default: return 16'(i * 37 + 5);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Physical memory: 1-cycle synchronous read.
    logic [15:0] mem [0:1023];
    bit mem_loaded = 0;
    always @(posedge clk1) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
            mem_loaded = 1;
        end
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state: one outstanding access, tracked by due cycles.
    logic [15:0] ref_mem [0:1023];
    bit          ref_loaded = 0;
    int          free_at = 0, pend_cyc = -1, done_cyc = -1, ptr_cyc = -1, m_starve = 0;
    bit          pend_fetch, pend_err, done_err, ptr_en;
    logic [15:0] pend_data, m_if_rdata = 16'h0, m_op_rdata = 16'h0;
    logic [9:0]  ptr_addr;
    bit          g_if, g_op, g_st, e_en, e_we, e_ifv, e_opv, e_operr, e_done, e_sterr, idle, ok, pok;
    logic [9:0]  e_addr, p;
    logic [15:0] e_wd;
    int          k;

    int last_op_v = -1, last_if_v = -1, last_st_done = -1, op_v_count = 0;
    logic [15:0] last_op_rdata;
    bit          last_op_err, last_st_err;
    logic [9:0]  addr_log [0:4095];
    bit          we_log [0:4095];

    always @(negedge clk1) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1;
        end
        k = pcyc;
        if (!rst) begin
            free_at = k + 1; pend_cyc = -1; done_cyc = -1; ptr_cyc = -1;
            m_starve = 0; m_if_rdata = 16'h0; m_op_rdata = 16'h0;
        end
        {g_if, g_op, g_st, e_en, e_we, e_ifv, e_opv, e_operr, e_done, e_sterr, ok} = '0;
        e_addr = '0; e_wd = '0;
        idle = (k >= free_at);
        if (rst) begin
            if (pend_cyc == k) begin
                if (pend_fetch) begin e_ifv = 1; m_if_rdata = pend_data; end
                else begin e_opv = 1; e_operr = pend_err; m_op_rdata = pend_data; end
            end
            if (done_cyc == k) begin e_done = 1; e_sterr = done_err; end
            if (ptr_cyc == k) begin e_en = ptr_en; e_addr = ptr_addr; end
            if (idle) begin
                if (if_req && m_starve == STV) g_if = 1;
                else if (st_req)               g_st = 1;
                else if (op_req)               g_op = 1;
                else if (if_req)               g_if = 1;
            end
            if (g_if) begin ok = int'(if_addr) < INS; e_en = ok; e_addr = if_addr; end
            if (g_st) begin
                ok = int'(st_addr) < 1024 - INS;
                e_en = ok; e_we = ok; e_addr = 10'(INS + int'(st_addr)); e_wd = st_wdata;
            end
            if (g_op) begin ok = int'(op_addr) < 1024 - INS; e_en = ok; e_addr = 10'(INS + int'(op_addr)); end
        end

        chk("if_gnt", if_gnt, g_if);
        chk("op_gnt", op_gnt, g_op);
        chk("st_gnt", st_gnt, g_st);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        chk("if_valid", if_valid, e_ifv);
        chk("op_valid", op_valid, e_opv);
        chk("op_err", op_err, e_operr);
        chk("st_done", st_done, e_done);
        chk("st_err", st_err, e_sterr);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("op_rdata", op_rdata, m_op_rdata);

        if (op_valid) begin last_op_v = k; last_op_rdata = op_rdata; last_op_err = op_err; op_v_count++; end
        if (if_valid) last_if_v = k;
        if (st_done) begin last_st_done = k; last_st_err = st_err; end
        if (k < 4096) begin addr_log[k] = mem_en ? mem_addr : 10'h0; we_log[k] = mem_we; end

        if (rst) begin
            if (!if_req || g_if) m_starve = 0;
            else if (idle && m_starve < STV) m_starve++;
            if (g_st) begin
                done_cyc = k + 1; done_err = !ok; free_at = k + 1;
                if (ok) ref_mem[INS + int'(st_addr)] = st_wdata;
            end
            if (g_if) begin
                pend_fetch = 1; pend_cyc = k + 2; pend_err = !ok; free_at = k + 2;
                pend_data = ok ? ref_mem[int'(if_addr)] : 16'h0;
            end
            if (g_op) begin
                pend_fetch = 0;
                if (!op_ind) begin
                    pend_cyc = k + 2; pend_err = !ok; free_at = k + 2;
                    pend_data = ok ? ref_mem[INS + int'(op_addr)] : 16'h0;
                end else begin
                    p = ok ? ref_mem[INS + int'(op_addr)][9:0] : 10'h0;
                    pok = ok && (int'(p) < 1024 - INS);
                    ptr_cyc = k + 1; ptr_en = pok; ptr_addr = 10'(INS + int'(p));
                    pend_cyc = k + 3; pend_err = !pok; free_at = k + 3;
                    pend_data = pok ? ref_mem[INS + int'(p)] : 16'h0;
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk1); #1; end
    endtask

    task automatic do_fetch(input logic [9:0] a, output int gc, output int rc);
        bit got = 0;
        gc = -1;
        @(posedge clk1); #1;
        if_req = 1; if_addr = a; rc = pcyc;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk1);
            if (if_gnt) begin got = 1; gc = pcyc; end
        end
        if (!got) chk("if_gnt_wait", if_gnt, 1);
        @(posedge clk1); #1;
        if_req = 0;
    endtask

    task automatic do_op(input logic [9:0] a, input logic ind, output int gc);
        bit got = 0;
        gc = -1;
        @(posedge clk1); #1;
        op_req = 1; op_addr = a; op_ind = ind;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk1);
            if (op_gnt) begin got = 1; gc = pcyc; end
        end
        if (!got) chk("op_gnt_wait", op_gnt, 1);
        @(posedge clk1); #1;
        op_req = 0;
    endtask

    task automatic do_store(input logic [9:0] a, input logic [15:0] d, output int gc);
        bit got = 0;
        gc = -1;
        @(posedge clk1); #1;
        st_req = 1; st_addr = a; st_wdata = d;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk1);
            if (st_gnt) begin got = 1; gc = pcyc; end
        end
        if (!got) chk("st_gnt_wait", st_gnt, 1);
        @(posedge clk1); #1;
        st_req = 0;
    endtask

    int g_st0, g_op0, g_if0, r0, g, r, vcount;

    initial begin
        if_req = 0; op_req = 0; op_ind = 0; st_req = 0;
        if_addr = '0; op_addr = '0; st_addr = '0; st_wdata = '0;
        rst = 1;
        #1 rst = 0;

        // Requests during reset must not be granted.
        @(posedge clk1); #1;
        if_req = 1; st_req = 1; st_addr = 10'd1;
        @(negedge clk1);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_st_gnt", st_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_op_rdata", op_rdata, 0);
        @(posedge clk1); #1;
        if_req = 0; st_req = 0;
        @(posedge clk1); #1;
        rst = 1;
        idle_cycles(2);

        // Three simultaneous requesters.
        fork
            do_store(10'd5, 16'hBEEF, g_st0);
            do_op(10'd5, 1'b0, g_op0);
            do_fetch(10'd0, g_if0, r0);
        join
        idle_cycles(4);
        chk("p23_op_gnt_delay", g_op0 - g_st0, 1);
        chk("p23_op_valid_delay", last_op_v - g_st0, 3);
        chk("p23_op_rdata", last_op_rdata, 16'hBEEF);
        chk("p23_if_gnt_delay", g_if0 - g_st0, 3);
        chk("p23_if_rdata", if_rdata, 16'hA5A5);

        // Indirect read through pointer at data word 2.
        do_op(10'd2, 1'b1, g);
        idle_cycles(4);
        chk("p24_addr_T", addr_log[g], 10'd403);
        chk("p24_addr_T1", addr_log[g + 1], 10'd408);
        chk("p24_valid_delay", last_op_v - g, 3);
        chk("p24_rdata", last_op_rdata, 16'h1234);

        // Starvation: stores held continuously while fetch waits.
        fork
            begin
                @(posedge clk1); #1;
                st_req = 1; st_addr = 10'd10; st_wdata = 16'h1111;
                repeat (10) @(posedge clk1);
                #1 st_req = 0;
            end
            begin
                @(posedge clk1);
                do_fetch(10'd3, g, r);
            end
        join
        idle_cycles(4);
        chk("p25_if_gnt_delay", g - r, STV);
        chk("p25_if_rdata", if_rdata, 16'h0F0F);

        // Out-of-range store, pointer and fetch.
        do_store(10'd623, 16'hDEAD, g);
        idle_cycles(2);
        chk("p26_st_done_delay", last_st_done - g, 1);
        chk("p26_st_err", last_st_err, 1);
        chk("p26_no_we", we_log[g], 0);
        do_op(10'd20, 1'b1, g);
        idle_cycles(4);
        chk("p26_op_valid_delay", last_op_v - g, 3);
        chk("p26_op_err", last_op_err, 1);
        chk("p26_op_rdata", op_rdata, 16'h0000);
        do_fetch(10'd401, g, r);
        idle_cycles(3);
        chk("p26_if_valid_delay", last_if_v - g, 2);
        chk("p26_if_rdata", if_rdata, 16'h0000);

        // Reset while an indirect read sits in PTR.
        do_op(10'd5, 1'b0, g);
        idle_cycles(3);
        chk("p27_pre_rdata", op_rdata, 16'hBEEF);
        do_op(10'd4, 1'b1, g);
        rst = 0;
        vcount = op_v_count;
        @(negedge clk1);
        chk("p27_rdata_cleared", op_rdata, 16'h0000);
        chk("p27_mem_en", mem_en, 0);
        @(posedge clk1); #1;
        @(posedge clk1); #1;
        rst = 1; if_req = 1; if_addr = 10'd0;
        @(negedge clk1);
        chk("p27_release_if_gnt", if_gnt, 1);
        @(posedge clk1); #1;
        if_req = 0;
        idle_cycles(6);
        chk("p27_no_op_valid", op_v_count - vcount, 0);
        chk("p27_if_rdata", if_rdata, 16'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
